// File: rtl/uart_sim_pkg.sv
// uart_sim_pkg: shared UART sim types.
// FSM state encoding and 8N1 frame constants.
package uart_sim_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_sim_tx_fifo.sv
// uart_sim_tx_fifo: synchronous byte FIFO.
// Ports: clk_i, rst_i (async, high), push_i/data_i in,
// pop_i/data_o out (show-ahead), full_o, empty_o.
module uart_sim_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // power-of-two depth: pointers wrap naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  assign data_o  = mem[rd_ptr];
  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);

endmodule

// File: rtl/uart_sim_transmitter.sv
// uart_sim_transmitter: 8N1 UART TX with buffer.
// Ports: clk_i, rst_i (async, high), data_i/valid_i/ready_o
// byte handshake, txd_o serial line (idle high), busy_o.
// UART_SIM_TRANSMITTER_FIFO_EN: FIFO_DEPTH-entry FIFO;
// undefined: single holding register.
module uart_sim_transmitter
  import uart_sim_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o,
  output logic       busy_o
);

  localparam int BAUD_VAL = CLOCK_FREQ / BAUD_RATE;
  localparam int CW =
    (BAUD_VAL > 1) ? $clog2(BAUD_VAL) : 1;
  localparam logic [CW-1:0] BAUD_TOP = CW'(BAUD_VAL - 1);

  tx_state_e     state;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  logic       push;
  logic       pop;
  logic       empty;
  logic [7:0] buf_data;

  assign push = valid_i && ready_o;

  // pop from IDLE, or on the last stop-bit cycle for
  // gapless back-to-back frames
  assign pop = !empty &&
    ((state == ST_IDLE) ||
     (state == ST_STOP && baud_cnt == '0));

`ifdef UART_SIM_TRANSMITTER_FIFO_EN
  logic full;

  uart_sim_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (data_i),
    .pop_i  (pop),
    .data_o (buf_data),
    .full_o (full),
    .empty_o(empty)
  );

  assign ready_o = !full;
`else
  logic        hold_valid;
  logic [7:0]  hold_data;
  logic [31:0] cfg_unused;

  assign cfg_unused = FIFO_DEPTH;

  // push needs empty, pop needs full: never both
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= data_i;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign ready_o  = !hold_valid;
  assign empty    = !hold_valid;
  assign buf_data = hold_data;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd_o    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= buf_data;
            baud_cnt <= BAUD_TOP;
            state    <= ST_START;
            txd_o    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_TOP;
            bit_cnt  <= 4'(UART_DATA_BITS);
            state    <= ST_DATA;
            txd_o    <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_TOP;
            shreg    <= shreg >> 1;
            bit_cnt  <= bit_cnt - 1'b1;
            if (bit_cnt == 4'd1) begin
              state <= ST_STOP;
              txd_o <= 1'b1;
            end else begin
              txd_o <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            if (pop) begin
              shreg    <= buf_data;
              baud_cnt <= BAUD_TOP;
              state    <= ST_START;
              txd_o    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE) || !empty;

endmodule
